// File: rtl/mux_rr_sel.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Selects a channel by fixed index (mode=0) or by round-robin arbitration (mode=1).
module mux_rr_sel #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SELW  = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
  output logic [CH-1:0]       in_ready,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  output logic [WIDTH-1:0]    out_data,
  output logic [SELW-1:0]     out_ch,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  grant_idx;
  logic             grant;
  logic             space;
  logic             transfer;
  logic [WIDTH-1:0] grant_data;

  assign space    = !out_valid || out_ready;
  assign transfer = space && grant;

  // Round-robin scan runs from the farthest offset back to ptr so the
  // closest valid channel (in scan order) is the one left standing.
  always_comb begin
    int idx;
    grant     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (!mode) begin
      for (int i = 0; i < CH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant     = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = CH - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= CH) idx = idx - CH;
        if (in_valid[idx]) begin
          grant     = 1'b1;
          grant_idx = SELW'(idx);
        end
      end
    end
  end

  // Ready is forced low while in reset so no producer sees a phantom handshake.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant_idx == SELW'(i)) begin
        in_ready[i] = rst_n && transfer;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      if (space) begin
        out_valid <= transfer;
        if (transfer) begin
          out_data <= grant_data;
          out_ch   <= grant_idx;
        end
      end
      if (transfer && mode) begin
        ptr <= (grant_idx == SELW'(CH - 1)) ? '0 : grant_idx + SELW'(1);
      end
    end
  end

endmodule
